inst_prefetch_buf: RTL and testbench
====================================

Name: inst_prefetch_buf

Overview:
- Instruction prefetch buffer between the instruction-fetch bus port and the if_id stage.
- Issues sequential word fetches ahead of decode and stores the returned instructions in a DEPTH-entry in-order FIFO.
- Presents one instruction plus its PC per cycle to if_id through a valid/ready handshake.
- On a redirect (jump, branch, interrupt from ctrl) it flushes, discards in-flight responses and restarts fetch at the target.

Parameters:
- DEPTH, 4, FIFO entries and also the maximum in-flight requests; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- INST_NOP, 32'h0000_0001, value driven on inst_o when no instruction is valid.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- jump_flag_i  in  1  redirect request from ctrl
- jump_addr_i  in  32  redirect target (word aligned)
- fetch_req_o  out  1  fetch request
- fetch_addr_o  out  32  fetch address
- fetch_gnt_i  in  1  request accepted this cycle
- fetch_rvalid_i  in  1  response data valid
- fetch_rdata_i  in  32  response instruction word
- inst_valid_o  out  1  inst_o/inst_addr_o valid
- inst_o  out  32  instruction to if_id
- inst_addr_o  out  32  PC of inst_o
- inst_ready_i  in  1  if_id consumes this cycle (low while the pipeline hold is active)
- occupancy_o  out  $clog2(DEPTH)+1  current FIFO fill, for debug and formal

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - fetch_pc=RESET_PC, out_pc=RESET_PC
  - fill, outstanding, drop counters = 0; FIFO pointers = 0
  - Outputs therefore read fetch_req_o=0, inst_valid_o=0, inst_o=INST_NOP, inst_addr_o=RESET_PC, occupancy_o=0.
  - Reset has priority over every other event, including mid-flight responses; those are lost.
- Bus protocol:
  - A request is accepted in a cycle where fetch_req_o && fetch_gnt_i.
  - Responses return in order, at least 1 cycle after grant, any latency.
  - fetch_addr_o = fetch_pc; fetch_pc += 4 on each accepted request.
- Request condition: fetch_req_o = !rst_q && !jump_flag_i && (fill + outstanding < DEPTH).
  - The fill + outstanding < DEPTH credit rule guarantees a response is never dropped for lack of space.
  - fetch_req_o is registered-free (combinational from state and jump_flag_i).
- Counter updates:
  - outstanding: +1 on an accepted request, −1 on each fetch_rvalid_i; both in one cycle leaves it unchanged.
  - Response with drop>0: drop −1, data discarded, no push.
  - Response with drop==0: push fetch_rdata_i into the FIFO.
  - fetch_rvalid_i with outstanding==0 is a protocol error: ignored, no counter underflow.
- Output side:
  - inst_valid_o = (fill != 0) && !jump_flag_i.
  - inst_o = FIFO head, or INST_NOP when !inst_valid_o.
  - inst_addr_o = out_pc.
  - Pop when inst_valid_o && inst_ready_i: head pointer advances and out_pc += 4.
  - Push and pop in the same cycle: fill unchanged, both pointers advance.
  - Output is combinational from the FIFO head, so zero-latency pass-through once data is stored. Minimum fetch-to-valid latency is 1 cycle after rvalid.
- Flush (jump_flag_i=1 at a clk edge):
  - FIFO emptied: fill=0, pointers reset.
  - fetch_pc=jump_addr_i, out_pc=jump_addr_i.
  - drop = outstanding_next, i.e. all in-flight requests including one granted this cycle, net of any response arriving this cycle.
  - No push or pop that cycle.
  - Next cycle requests resume at jump_addr_i if credit allows.
- Back-to-back jumps: each recomputes drop from the current outstanding; the last target wins.
- Wrap-around:
  - FIFO pointers wrap modulo DEPTH.
  - fetch_pc and out_pc wrap modulo 2^32 (0xFFFF_FFFC+4 → 0).
- Full: fill==DEPTH implies outstanding==0 and fetch_req_o=0; the buffer stalls until a pop.

Decomposition:
- Shared package/defines:
  - INST_NOP and reset PC constants already in defines.v
  - fetch bus widths (MemAddrBus, InstBus)
- One sub-module, sync_fifo: DEPTH x 32-bit memory with push/pop/flush, fill count, full/empty.
- Counters, drop logic and PC tracking stay in inst_prefetch_buf.

Test Plan:
- Reset, then grant always with rvalid 1 cycle later, ready=1 → fetch addresses 0,4,8,…; inst_valid_o first high 2 cycles after the first grant, inst_addr_o 0,4,8 in order with data matching.
- ready=0 for 10 cycles with immediate grants → exactly 4 requests issued, occupancy_o=4, fetch_req_o=0; one pop re-enables exactly one request.
- 3 requests outstanding, jump_flag_i with jump_addr_i=0x100 → next request addr 0x100; the 3 stale responses are discarded; first inst_addr_o after flush = 0x100 with the 0x100 data.
- jump_flag_i in the same cycle as a grant and a stale rvalid → drop count correct; no stale word ever reaches inst_o; inst_valid_o=0 in the jump cycle.
- jump_addr_i=0xFFFF_FFF8, 4 fetches → addresses FFFF_FFF8, FFFF_FFFC, 0, 4; FIFO pointer wrap preserves order.
- rst asserted with 2 outstanding and 2 stored → next cycle occupancy_o=0, inst_o=INST_NOP, fetch_addr_o=RESET_PC; late rvalids ignored without underflow.

Source files
------------

// File: rtl/inst_prefetch_buf_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
// Bus widths and the reset/NOP values live here so the core and the bench agree on them.
package inst_prefetch_buf_pkg;

    localparam int MemAddrBus = 32;
    localparam int InstBus    = 32;

    localparam logic [MemAddrBus-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [InstBus-1:0]    INST_NOP_DEF = 32'h0000_0001;

    typedef logic [MemAddrBus-1:0] addr_t;
    typedef logic [InstBus-1:0]    inst_t;

    // Sequential word step; wraps naturally at 2^32.
    function automatic addr_t pcNext(input addr_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_prefetch_buf_if.sv
// Fetch-bus and instruction-stream signals of the prefetch buffer.
// master = the prefetch buffer itself, slave = memory/if_id side.
interface inst_prefetch_buf_if;
    import inst_prefetch_buf_pkg::*;

    logic  fetch_req_o;
    addr_t fetch_addr_o;
    logic  fetch_gnt_i;
    logic  fetch_rvalid_i;
    inst_t fetch_rdata_i;

    logic  inst_valid_o;
    inst_t inst_o;
    addr_t inst_addr_o;
    logic  inst_ready_i;

    modport master (
        output fetch_req_o, fetch_addr_o, inst_valid_o, inst_o, inst_addr_o,
        input  fetch_gnt_i, fetch_rvalid_i, fetch_rdata_i, inst_ready_i
    );

    modport slave (
        input  fetch_req_o, fetch_addr_o, inst_valid_o, inst_o, inst_addr_o,
        output fetch_gnt_i, fetch_rvalid_i, fetch_rdata_i, inst_ready_i
    );

endinterface

// File: rtl/inst_prefetch_buf_sync_fifo.sv
// DEPTH x 32-bit in-order FIFO with flush; head data is read combinationally.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module inst_prefetch_buf_sync_fifo
    import inst_prefetch_buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  inst_t                  pushData_i,
    input  logic                   pop_i,
    output inst_t                  headData_o,
    output logic [$clog2(DEPTH):0] fill_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PtrW = $clog2(DEPTH);
    localparam int CntW = PtrW + 1;

    logic [PtrW-1:0] wrPtr_q, wrPtr_d;
    logic [PtrW-1:0] rdPtr_q, rdPtr_d;
    logic [CntW-1:0] fill_q, fill_d;
    inst_t           mem_q [DEPTH];
    logic            pushEn, popEn;

    assign full_o     = (fill_q == CntW'(DEPTH));
    assign empty_o    = (fill_q == '0);
    assign fill_o     = fill_q;
    assign headData_o = mem_q[rdPtr_q];

    // A flush wins over any push/pop in the same cycle.
    always_comb begin
        pushEn  = push_i && !full_o && !flush_i;
        popEn   = pop_i && !empty_o && !flush_i;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        fill_d  = fill_q;
        if (pushEn) wrPtr_d = wrPtr_q + PtrW'(1);
        if (popEn)  rdPtr_d = rdPtr_q + PtrW'(1);
        case ({pushEn, popEn})
            2'b10:   fill_d = fill_q + CntW'(1);
            2'b01:   fill_d = fill_q - CntW'(1);
            default: fill_d = fill_q;
        endcase
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            fill_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            fill_q  <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            fill_q  <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) mem_q[wrPtr_q] <= pushData_i;
    end

endmodule

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch buffer: runs sequential fetches ahead of decode, queues the words
// in order and hands them to if_id; a redirect flushes and drops in-flight responses.
module inst_prefetch_buf
    import inst_prefetch_buf_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter addr_t RESET_PC = RESET_PC_DEF,
    parameter inst_t INST_NOP = INST_NOP_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   jump_flag_i,
    input  addr_t                  jump_addr_i,
    inst_prefetch_buf_if.master    bus,
    output logic [$clog2(DEPTH):0] occupancy_o
);

    localparam int CntW = $clog2(DEPTH) + 1;

    logic            rst_q;
    addr_t           fetchPc_q, fetchPc_d;
    addr_t           outPc_q, outPc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_q, drop_d;

    logic [CntW-1:0] fill;
    logic [CntW:0]   inFlight;
    logic            fifoFull, fifoEmpty;
    inst_t           fifoHead;
    logic            credit, fetchReq, reqAccept, rspValid, rspDrop;
    logic            pushEn, popEn, instValid;

    inst_prefetch_buf_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (jump_flag_i),
        .push_i     (pushEn),
        .pushData_i (bus.fetch_rdata_i),
        .pop_i      (popEn),
        .headData_o (fifoHead),
        .fill_o     (fill),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    // Credit counts stored words plus in-flight requests, so every response has a slot.
    // An rvalid with nothing outstanding is a bus error and is ignored.
    always_comb begin
        inFlight  = {1'b0, fill} + {1'b0, outstanding_q};
        credit    = inFlight < (CntW + 1)'(DEPTH);
        fetchReq  = !rst_q && !jump_flag_i && credit && !fifoFull;
        reqAccept = fetchReq && bus.fetch_gnt_i;
        rspValid  = bus.fetch_rvalid_i && (outstanding_q != '0);
        rspDrop   = rspValid && (drop_q != '0);
        pushEn    = rspValid && !rspDrop && !jump_flag_i;
        instValid = !fifoEmpty && !jump_flag_i;
        popEn     = instValid && bus.inst_ready_i;
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (reqAccept && !rspValid)      outstanding_d = outstanding_q + CntW'(1);
        else if (!reqAccept && rspValid) outstanding_d = outstanding_q - CntW'(1);

        drop_d    = rspDrop ? drop_q - CntW'(1) : drop_q;
        fetchPc_d = reqAccept ? pcNext(fetchPc_q) : fetchPc_q;
        outPc_d   = popEn ? pcNext(outPc_q) : outPc_q;

        // Everything still in flight after this cycle belongs to the old stream.
        if (jump_flag_i) begin
            drop_d    = outstanding_d;
            fetchPc_d = jump_addr_i;
            outPc_d   = jump_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            fetchPc_q     <= RESET_PC;
            outPc_q       <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetchPc_q     <= fetchPc_d;
            outPc_q       <= outPc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    assign bus.fetch_req_o  = fetchReq;
    assign bus.fetch_addr_o = fetchPc_q;
    assign bus.inst_valid_o = instValid;
    assign bus.inst_o       = instValid ? fifoHead : INST_NOP;
    assign bus.inst_addr_o  = outPc_q;
    assign occupancy_o      = fill;

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Bench for inst_prefetch_buf: a per-cycle vector table for streaming/backpressure,
// then hand-written sequences for redirects, address wrap and reset mid-flight.
module tb_inst_prefetch_buf;
    import inst_prefetch_buf_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0001;

    typedef struct {
        logic        ready;
        logic        expReq;
        logic [31:0] expFetchAddr;
        logic        expValid;
        logic [31:0] expAddr;
        logic [2:0]  expOcc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        jumpFlag;
    logic [31:0] jumpAddr;
    logic [2:0]  occ;

    int          checks = 0;
    int          errors = 0;
    bit          autoResp = 1'b0;
    logic [31:0] pendQ[$];
    logic [31:0] issuedQ[$];
    vec_t        vecs [21];

    inst_prefetch_buf_if bif ();

    inst_prefetch_buf dut (
        .clk         (clk),
        .rst         (rst),
        .jump_flag_i (jumpFlag),
        .jump_addr_i (jumpAddr),
        .bus         (bif.master),
        .occupancy_o (occ)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Instruction memory contents as seen by the bench.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One clock: sample the bus at the negedge, then model a 1-cycle in-order memory.
    task automatic tick();
        bit          acc;
        bit          rv;
        logic [31:0] a;
        @(negedge clk);
        acc = (bif.fetch_req_o === 1'b1) && (bif.fetch_gnt_i === 1'b1);
        rv  = (bif.fetch_rvalid_i === 1'b1);
        a   = bif.fetch_addr_o;
        @(posedge clk);
        #1;
        if (rv && pendQ.size() > 0) void'(pendQ.pop_front());
        if (acc) begin
            pendQ.push_back(a);
            issuedQ.push_back(a);
        end
        if (autoResp && pendQ.size() > 0) begin
            bif.fetch_rvalid_i = 1'b1;
            bif.fetch_rdata_i  = memWord(pendQ[0]);
        end else begin
            bif.fetch_rvalid_i = 1'b0;
            bif.fetch_rdata_i  = 32'h0;
        end
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        bif.inst_ready_i = v.ready;
        tick();
    endtask

    task automatic doReset();
        rst = 1'b1; jumpFlag = 1'b0; autoResp = 1'b0;
        bif.fetch_gnt_i = 1'b0; bif.inst_ready_i = 1'b0;
        bif.fetch_rvalid_i = 1'b0; bif.fetch_rdata_i = 32'h0;
        tick();
        tick();
        pendQ.delete();
        rst = 1'b0;
        tick();
    endtask

    // Pops with ready=1 and expects `count` consecutive words starting at startAddr.
    task automatic expectStream(input string name, input logic [31:0] startAddr, input int count, input int budget);
        logic [31:0] exp;
        int          got;
        exp = startAddr;
        got = 0;
        for (int c = 0; c < budget && got < count; c++) begin
            tick();
            if (bif.inst_valid_o === 1'b1) begin
                checkOutput($sformatf("%s_addr%0d", name, got), bif.inst_addr_o, exp);
                checkOutput($sformatf("%s_inst%0d", name, got), bif.inst_o, memWord(exp));
                exp = exp + 32'd4;
                got++;
            end
        end
        if (got < count) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d words, required %0d", name, got, count);
        end
    endtask

    initial begin
        logic [31:0] expIss [4];
        int          w;

        // ready, req, fetch_addr, valid, inst_addr, occupancy (one row per clock)
        vecs[0]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  3'd0};
        vecs[1]  = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0,  3'd0};
        vecs[2]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd0,  3'd1};
        vecs[3]  = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd4,  3'd1};
        vecs[4]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd8,  3'd1};
        vecs[5]  = '{1'b0, 1'b1, 32'd20, 1'b1, 32'd8,  3'd2};
        vecs[6]  = '{1'b0, 1'b0, 32'd24, 1'b1, 32'd8,  3'd3};
        for (int i = 7; i <= 14; i++) vecs[i] = '{1'b0, 1'b0, 32'd24, 1'b1, 32'd8, 3'd4};
        vecs[15] = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd12, 3'd3};
        vecs[16] = '{1'b0, 1'b0, 32'd28, 1'b1, 32'd12, 3'd3};
        vecs[17] = '{1'b0, 1'b0, 32'd28, 1'b1, 32'd12, 3'd4};
        vecs[18] = '{1'b1, 1'b1, 32'd28, 1'b1, 32'd16, 3'd3};
        vecs[19] = '{1'b1, 1'b1, 32'd32, 1'b1, 32'd20, 3'd2};
        vecs[20] = '{1'b1, 1'b1, 32'd36, 1'b1, 32'd24, 3'd2};

        rst = 1'b1; jumpFlag = 1'b0; jumpAddr = 32'h0;
        bif.fetch_gnt_i = 1'b0; bif.fetch_rvalid_i = 1'b0;
        bif.fetch_rdata_i = 32'h0; bif.inst_ready_i = 1'b0;
        tick();
        tick();
        checkOutput("rst_req",       32'(bif.fetch_req_o),  32'd0);
        checkOutput("rst_valid",     32'(bif.inst_valid_o), 32'd0);
        checkOutput("rst_inst",      bif.inst_o,            NOP);
        checkOutput("rst_inst_addr", bif.inst_addr_o,       32'h0);
        checkOutput("rst_occ",       32'(occ),              32'd0);

        $display("[TB] streaming and backpressure vectors");
        rst = 1'b0;
        bif.fetch_gnt_i = 1'b1;
        autoResp = 1'b1;
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_req", i),   32'(bif.fetch_req_o),  32'(vecs[i].expReq));
            checkOutput($sformatf("vec%0d_faddr", i), bif.fetch_addr_o,      vecs[i].expFetchAddr);
            checkOutput($sformatf("vec%0d_valid", i), 32'(bif.inst_valid_o), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_iaddr", i), bif.inst_addr_o,       vecs[i].expAddr);
            checkOutput($sformatf("vec%0d_inst", i),  bif.inst_o,
                        vecs[i].expValid ? memWord(vecs[i].expAddr) : NOP);
            checkOutput($sformatf("vec%0d_occ", i),   32'(occ),              32'(vecs[i].expOcc));
        end

        $display("[TB] redirect with three requests in flight");
        doReset();
        bif.fetch_gnt_i = 1'b1; bif.inst_ready_i = 1'b1;
        tick(); tick(); tick();
        bif.fetch_gnt_i = 1'b0;
        checkOutput("jmpA_pre_faddr", bif.fetch_addr_o, 32'd12);
        jumpFlag = 1'b1; jumpAddr = 32'h100; autoResp = 1'b1;
        #1;
        checkOutput("jmpA_jcyc_req",   32'(bif.fetch_req_o),  32'd0);
        checkOutput("jmpA_jcyc_valid", 32'(bif.inst_valid_o), 32'd0);
        tick();
        jumpFlag = 1'b0; bif.fetch_gnt_i = 1'b1;
        #1;
        checkOutput("jmpA_faddr", bif.fetch_addr_o,     32'h100);
        checkOutput("jmpA_req",   32'(bif.fetch_req_o), 32'd1);
        w = 0;
        while (bif.inst_valid_o !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        checkOutput("jmpA_latency", 32'(w),           32'd4);
        checkOutput("jmpA_addr0",   bif.inst_addr_o,  32'h100);
        checkOutput("jmpA_inst0",   bif.inst_o,       memWord(32'h100));
        expectStream("jmpA", 32'h104, 3, 30);

        $display("[TB] redirect coinciding with grant and stale response");
        doReset();
        bif.fetch_gnt_i = 1'b1; bif.inst_ready_i = 1'b0; autoResp = 1'b1;
        tick(); tick();
        autoResp = 1'b0;
        tick(); tick();
        checkOutput("jmpB_pre_occ", 32'(occ),             32'd2);
        checkOutput("jmpB_pre_req", 32'(bif.fetch_req_o), 32'd0);
        bif.fetch_rvalid_i = 1'b1; bif.fetch_rdata_i = memWord(32'd8);
        jumpFlag = 1'b1; jumpAddr = 32'h200;
        #1;
        checkOutput("jmpB_jcyc_valid", 32'(bif.inst_valid_o), 32'd0);
        checkOutput("jmpB_jcyc_inst",  bif.inst_o,             NOP);
        tick();
        jumpFlag = 1'b0; autoResp = 1'b1; bif.inst_ready_i = 1'b1;
        #1;
        checkOutput("jmpB_occ",   32'(occ),         32'd0);
        checkOutput("jmpB_faddr", bif.fetch_addr_o, 32'h200);
        expectStream("jmpB", 32'h200, 3, 30);

        $display("[TB] address and pointer wrap");
        doReset();
        bif.fetch_gnt_i = 1'b1; bif.inst_ready_i = 1'b1; autoResp = 1'b1;
        jumpFlag = 1'b1; jumpAddr = 32'hFFFF_FFF8;
        issuedQ.delete();
        tick();
        jumpFlag = 1'b0;
        expectStream("wrap", 32'hFFFF_FFF8, 6, 40);
        expIss[0] = 32'hFFFF_FFF8; expIss[1] = 32'hFFFF_FFFC;
        expIss[2] = 32'h0000_0000; expIss[3] = 32'h0000_0004;
        if (issuedQ.size() < 4) begin
            checks++;
            errors++;
            $display("[TB] FAIL wrap_issued: got %0d requests, required at least 4", issuedQ.size());
        end else begin
            for (int i = 0; i < 4; i++)
                checkOutput($sformatf("wrap_issue%0d", i), issuedQ[i], expIss[i]);
        end

        $display("[TB] reset with data stored and requests in flight");
        doReset();
        bif.fetch_gnt_i = 1'b1; bif.inst_ready_i = 1'b0; autoResp = 1'b1;
        tick(); tick();
        autoResp = 1'b0;
        tick(); tick();
        checkOutput("rstB_pre_occ", 32'(occ), 32'd2);
        rst = 1'b1;
        tick();
        checkOutput("rstB_occ",   32'(occ),              32'd0);
        checkOutput("rstB_valid", 32'(bif.inst_valid_o), 32'd0);
        checkOutput("rstB_inst",  bif.inst_o,            NOP);
        checkOutput("rstB_faddr", bif.fetch_addr_o,      32'h0);
        checkOutput("rstB_iaddr", bif.inst_addr_o,       32'h0);
        rst = 1'b0; bif.fetch_gnt_i = 1'b0;
        pendQ.delete();
        for (int i = 0; i < 2; i++) begin
            bif.fetch_rvalid_i = 1'b1; bif.fetch_rdata_i = 32'hDEAD_BEEF;
            tick();
        end
        checkOutput("rstB_late_occ",   32'(occ),              32'd0);
        checkOutput("rstB_late_valid", 32'(bif.inst_valid_o), 32'd0);
        checkOutput("rstB_late_req",   32'(bif.fetch_req_o),  32'd1);
        checkOutput("rstB_late_faddr", bif.fetch_addr_o,      32'h0);
        bif.fetch_gnt_i = 1'b1; bif.inst_ready_i = 1'b1; autoResp = 1'b1;
        expectStream("rstB", 32'h0, 2, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
